// File: rtl/if_unit_if.sv
// IF-stage bus: stall/redirect control in, instruction-memory read port, IF/ID decode fields out.
interface if_unit_if #(parameter int IMEM_AW = 14);
  logic               stall;
  logic               redirect_en;
  logic [31:0]        redirect_pc;
  logic               imem_rd_en;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_rdata;
  logic               inst_valid;
  logic [31:0]        PC_out;
  logic [5:0]         opcode;
  logic [4:0]         R_I_A_type_rs;
  logic [4:0]         R_type_rd;
  logic [4:0]         R_I_type_rt;
  logic [4:0]         R_type_shamt;
  logic [5:0]         R_funct_S_snum;
  logic [15:0]        I_type_imm;
  logic [20:0]        A_type_imm;
  logic [25:0]        J_type_imm;
  logic               halted;

  modport master (
    input  stall, redirect_en, redirect_pc, imem_rdata,
    output imem_rd_en, imem_addr, inst_valid, PC_out, opcode, R_I_A_type_rs, R_type_rd,
           R_I_type_rt, R_type_shamt, R_funct_S_snum, I_type_imm, A_type_imm, J_type_imm, halted
  );

  modport slave (
    output stall, redirect_en, redirect_pc, imem_rdata,
    input  imem_rd_en, imem_addr, inst_valid, PC_out, opcode, R_I_A_type_rs, R_type_rd,
           R_I_type_rt, R_type_shamt, R_funct_S_snum, I_type_imm, A_type_imm, J_type_imm, halted
  );
endinterface

// File: rtl/if_unit.sv
// Instruction fetch: owns PC, drives 1-cycle sync imem, registers IF/ID with a one-entry skid for stalls.
// Optional halt detection is enabled by defining HALT_DETECT_EN.
module if_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          IMEM_AW     = 14,
  parameter logic [5:0]  HALT_OPCODE = 6'h3F
) (
  input  logic      clk,
  input  logic      rst,
  if_unit_if.master bus
);

  logic [31:0] pc;
  logic        inflight_valid;
  logic [31:0] inflight_pc;
  logic        skid_valid;
  logic [31:0] skid_inst;
  logic [31:0] skid_pc;
  logic        inst_valid_q;
  logic [31:0] inst_q;
  logic [31:0] pc_out_q;
  logic        halted_q;
  logic        issue;
  logic        load_vld;
  logic [31:0] load_inst;
  logic [31:0] load_pc;
  logic        halt_hit;

  assign issue = !rst && !bus.stall && !halted_q;

  // A held skid entry is always older than the live response, so it loads first.
  always_comb begin
    load_vld  = 1'b0;
    load_inst = bus.imem_rdata;
    load_pc   = inflight_pc;
    if (skid_valid) begin
      load_vld  = 1'b1;
      load_inst = skid_inst;
      load_pc   = skid_pc;
    end else if (inflight_valid) begin
      load_vld  = 1'b1;
    end
  end

`ifdef HALT_DETECT_EN
  assign halt_hit = load_vld && !bus.stall && !bus.redirect_en && (load_inst[31:26] == HALT_OPCODE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halted_q <= 1'b0;
    end else if (bus.redirect_en) begin
      halted_q <= 1'b0;
    end else if (halt_hit) begin
      halted_q <= 1'b1;
    end
  end
`else
  logic unused_halt_opcode;
  assign unused_halt_opcode = ^HALT_OPCODE;
  assign halt_hit           = 1'b0;
  assign halted_q           = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc             <= RESET_PC;
      inflight_valid <= 1'b0;
      inflight_pc    <= 32'h0;
      skid_valid     <= 1'b0;
      skid_inst      <= 32'h0;
      skid_pc        <= 32'h0;
      inst_valid_q   <= 1'b0;
      inst_q         <= 32'h0;
      pc_out_q       <= 32'h0;
    end else if (bus.redirect_en) begin
      pc             <= bus.redirect_pc;
      inflight_valid <= 1'b0;
      skid_valid     <= 1'b0;
      inst_valid_q   <= 1'b0;
    end else if (bus.stall) begin
      // No issue happens while stalled, so the skid can never already be occupied here.
      if (inflight_valid) begin
        skid_valid <= 1'b1;
        skid_inst  <= bus.imem_rdata;
        skid_pc    <= inflight_pc;
      end
      inflight_valid <= 1'b0;
    end else begin
      skid_valid   <= 1'b0;
      inst_valid_q <= load_vld;
      if (load_vld) begin
        inst_q   <= load_inst;
        pc_out_q <= load_pc + 32'd1;
      end
      if (halt_hit) begin
        inflight_valid <= 1'b0;
        pc             <= load_pc + 32'd1;
      end else begin
        inflight_valid <= issue;
        inflight_pc    <= pc;
        if (issue) begin
          pc <= pc + 32'd1;
        end
      end
    end
  end

  assign bus.imem_rd_en     = issue;
  assign bus.imem_addr      = pc[IMEM_AW-1:0];
  assign bus.inst_valid     = inst_valid_q;
  assign bus.PC_out         = pc_out_q;
  assign bus.opcode         = inst_q[31:26];
  assign bus.R_I_A_type_rs  = inst_q[25:21];
  assign bus.R_type_rd      = inst_q[20:16];
  assign bus.R_I_type_rt    = inst_q[15:11];
  assign bus.R_type_shamt   = inst_q[10:6];
  assign bus.R_funct_S_snum = inst_q[5:0];
  assign bus.I_type_imm     = inst_q[15:0];
  assign bus.A_type_imm     = inst_q[20:0];
  assign bus.J_type_imm     = inst_q[25:0];
  assign bus.halted         = halted_q;

endmodule

// File: tb/tb_if_unit.sv
// Bench for if_unit: queue-based fetch-order model checked every cycle, plus directed literal checks.
module tb_if_unit;
  localparam int AW = 14;

  logic clk;
  logic rst;
  int   errs   = 0;
  int   checks = 0;

  if_unit_if #(.IMEM_AW(AW)) bus();

  if_unit #(.RESET_PC(32'h0), .IMEM_AW(AW), .HALT_OPCODE(6'h3F)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [31:0] mem [0:(1<<AW)-1];

  always @(posedge clk) begin
    if (bus.imem_rd_en) bus.imem_rdata <= mem[bus.imem_addr];
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: addresses fetched but not yet delivered wait in a queue; delivery pops the oldest.
  logic [31:0] m_pc     = 32'h0;
  logic        m_valid  = 1'b0;
  logic [31:0] m_word   = 32'h0;
  logic [31:0] m_pcout  = 32'h0;
  logic        m_halted = 1'b0;
  logic [31:0] q[$];
  logic [31:0] m_a;
  bit          fetch_now;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc = 32'h0; m_valid = 1'b0; m_word = 32'h0; m_pcout = 32'h0; m_halted = 1'b0;
      q.delete();
    end else if (bus.redirect_en) begin
      m_pc = bus.redirect_pc; m_valid = 1'b0; m_halted = 1'b0;
      q.delete();
    end else if (!bus.stall) begin
      fetch_now = !m_halted;
      if (q.size() != 0) begin
        m_a     = q.pop_front();
        m_valid = 1'b1;
        m_word  = mem[m_a[AW-1:0]];
        m_pcout = m_a + 32'd1;
`ifdef HALT_DETECT_EN
        if (m_word[31:26] == 6'h3F) begin
          m_halted  = 1'b1;
          fetch_now = 1'b0;
          m_pc      = m_a + 32'd1;
          q.delete();
        end
`endif
      end else begin
        m_valid = 1'b0;
      end
      if (fetch_now) begin
        q.push_back(m_pc);
        m_pc = m_pc + 32'd1;
      end
    end
  end

  always @(negedge clk) begin
    logic exp_rd;
    exp_rd = !rst && !bus.stall && !m_halted;
    check("inst_valid", {31'h0, bus.inst_valid}, {31'h0, m_valid});
    check("imem_rd_en", {31'h0, bus.imem_rd_en}, {31'h0, exp_rd});
    if (exp_rd) check("imem_addr", {{(32-AW){1'b0}}, bus.imem_addr}, {{(32-AW){1'b0}}, m_pc[AW-1:0]});
    check("PC_out", bus.PC_out, m_pcout);
    check("opcode", {26'h0, bus.opcode}, {26'h0, m_word[31:26]});
    check("rs", {27'h0, bus.R_I_A_type_rs}, {27'h0, m_word[25:21]});
    check("rd", {27'h0, bus.R_type_rd}, {27'h0, m_word[20:16]});
    check("rt", {27'h0, bus.R_I_type_rt}, {27'h0, m_word[15:11]});
    check("shamt", {27'h0, bus.R_type_shamt}, {27'h0, m_word[10:6]});
    check("funct", {26'h0, bus.R_funct_S_snum}, {26'h0, m_word[5:0]});
    check("I_imm", {16'h0, bus.I_type_imm}, {16'h0, m_word[15:0]});
    check("A_imm", {11'h0, bus.A_type_imm}, {11'h0, m_word[20:0]});
    check("J_imm", {6'h0, bus.J_type_imm}, {6'h0, m_word[25:0]});
    check("halted", {31'h0, bus.halted}, {31'h0, m_halted});
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst             = 1'b1;
    bus.stall       = 1'b0;
    bus.redirect_en = 1'b0;
    bus.redirect_pc = 32'h0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h1000_0000 + i;
    mem[32'h40] = 32'hFFFF_8001;

    // Reset state
    step(3);
    check("lit_rst_valid", {31'h0, bus.inst_valid}, 32'h0);
    check("lit_rst_pcout", bus.PC_out, 32'h0);
    check("lit_rst_rden", {31'h0, bus.imem_rd_en}, 32'h0);
    rst = 1'b0;

    // Stream from reset: first valid in cycle 2, PC_out 1,2,3 with opcode 4
    step(1);
    check("lit_c1_valid", {31'h0, bus.inst_valid}, 32'h0);
    step(1);
    check("lit_c2_valid", {31'h0, bus.inst_valid}, 32'h1);
    check("lit_c2_pcout", bus.PC_out, 32'h1);
    check("lit_c2_opcode", {26'h0, bus.opcode}, 32'h4);
    step(1);
    check("lit_c3_pcout", bus.PC_out, 32'h2);
    step(1);
    check("lit_c4_pcout", bus.PC_out, 32'h3);
    step(2);
    check("lit_c6_pcout", bus.PC_out, 32'h5);

    // Three-cycle stall at PC_out=5
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("lit_stall_hold", bus.PC_out, 32'h5);
      check("lit_stall_valid", {31'h0, bus.inst_valid}, 32'h1);
    end
    bus.stall = 1'b0;
    for (int i = 6; i <= 8; i++) begin
      step(1);
      check("lit_resume_pcout", bus.PC_out, i);
    end

    // Redirect while stalled
    bus.stall = 1'b1;
    step(1);
    bus.redirect_en = 1'b1;
    bus.redirect_pc = 32'h0000_0100;
    step(1);
    check("lit_redir_kill", {31'h0, bus.inst_valid}, 32'h0);
    bus.redirect_en = 1'b0;
    step(1);
    check("lit_redir_stall_valid", {31'h0, bus.inst_valid}, 32'h0);
    check("lit_redir_stall_rden", {31'h0, bus.imem_rd_en}, 32'h0);
    bus.stall = 1'b0;
    step(1);
    check("lit_redir_gap", {31'h0, bus.inst_valid}, 32'h0);
    step(1);
    check("lit_redir_valid", {31'h0, bus.inst_valid}, 32'h1);
    check("lit_redir_pcout", bus.PC_out, 32'h101);
    step(2);

    // Field split
    bus.redirect_en = 1'b1;
    bus.redirect_pc = 32'h40;
    step(1);
    bus.redirect_en = 1'b0;
    check("lit_fs_addr", {{(32-AW){1'b0}}, bus.imem_addr}, 32'h40);
    step(2);
    check("lit_fs_valid", {31'h0, bus.inst_valid}, 32'h1);
    check("lit_fs_pcout", bus.PC_out, 32'h41);
    check("lit_fs_rs", {27'h0, bus.R_I_A_type_rs}, 32'h1F);
    check("lit_fs_rd", {27'h0, bus.R_type_rd}, 32'h1F);
    check("lit_fs_rt", {27'h0, bus.R_I_type_rt}, 32'h10);
    check("lit_fs_shamt", {27'h0, bus.R_type_shamt}, 32'h0);
    check("lit_fs_funct", {26'h0, bus.R_funct_S_snum}, 32'h1);
    check("lit_fs_iimm", {16'h0, bus.I_type_imm}, 32'h8001);
    step(3);

    // PC wrap
    bus.redirect_en = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFF;
    step(1);
    bus.redirect_en = 1'b0;
    check("lit_wrap_addr_hi", {{(32-AW){1'b0}}, bus.imem_addr}, 32'h3FFF);
    step(1);
    check("lit_wrap_addr_lo", {{(32-AW){1'b0}}, bus.imem_addr}, 32'h0);
    step(1);
    check("lit_wrap_valid", {31'h0, bus.inst_valid}, 32'h1);
    check("lit_wrap_pcout", bus.PC_out, 32'h0);
    step(1);
    check("lit_wrap_next", bus.PC_out, 32'h1);
    step(3);

`ifdef HALT_DETECT_EN
    // HALT at address 3
    rst = 1'b1;
    step(2);
    mem[3] = 32'hFC00_0000;
    rst = 1'b0;
    step(5);
    check("lit_halt_pcout", bus.PC_out, 32'h4);
    check("lit_halt_flag", {31'h0, bus.halted}, 32'h1);
    check("lit_halt_rden", {31'h0, bus.imem_rd_en}, 32'h0);
    step(1);
    check("lit_halt_after", {31'h0, bus.inst_valid}, 32'h0);
    step(3);
    check("lit_halt_still", {31'h0, bus.imem_rd_en}, 32'h0);
    bus.redirect_en = 1'b1;
    bus.redirect_pc = 32'h10;
    step(1);
    bus.redirect_en = 1'b0;
    step(2);
    check("lit_halt_restart", bus.PC_out, 32'h11);
    check("lit_halt_clear", {31'h0, bus.halted}, 32'h0);
    step(3);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
